// File: rtl/sqrt_seq_ctrl_if.sv
// rtl/sqrt_seq_ctrl_if.sv - operand/result handshake bundle for sqrt_seq_ctrl
interface sqrt_seq_ctrl_if #(
    parameter int NBITSIN = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NBITSIN-1:0]     in_x;
    logic                   out_valid;
    logic                   out_ready;
    logic [NBITSIN/2-1:0]   out_root;

    // master: upstream producer plus downstream consumer; slave: the controller
    modport master (
        output in_valid,
        output in_x,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_root
    );

    modport slave (
        input  in_valid,
        input  in_x,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_root
    );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - sequencer that feeds one operand at a time to a multi-cycle sqrt core
module sqrt_seq_ctrl #(
    parameter int NBITSIN = 32,
    parameter int LATENCY = NBITSIN / 2
) (
    input  logic                   clock,
    input  logic                   reset,
    sqrt_seq_ctrl_if.slave         bus,
    output logic                   core_start,
    output logic                   core_stop,
    output logic [NBITSIN-1:0]     core_xin,
    input  logic [NBITSIN/2-1:0]   core_sqrt,
    output logic [15:0]            op_count
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        STOP  = 3'd3,
        CAPT  = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [NBITSIN/2-1:0]   out_root_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_root  = out_root_q;

    // Pulses are set on the edge entering START/STOP, so each lasts exactly one state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
            core_start  <= 1'b0;
            core_stop   <= 1'b0;
            core_xin    <= '0;
            op_count    <= '0;
        end else begin
            core_start <= 1'b0;
            core_stop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        core_xin   <= bus.in_x;
                        in_ready_q <= 1'b0;
                        core_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    cnt   <= CW'(LATENCY);
                    state <= RUN;
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        cnt       <= '0;
                        core_stop <= 1'b1;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STOP: begin
                    state <= CAPT;
                end
                CAPT: begin
                    out_root_q  <= core_sqrt;
                    out_valid_q <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    // HOLD never accepts, so the falling edge of out_valid cannot overlap a new operand.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        op_count    <= op_count + 16'd1;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sqrt_seq_ctrl.md
SQRT_SEQ_CTRL -- requirements
Module: sqrt_seq_ctrl

Interface
REQ-001 SHALL have parameter NBITSIN, default 32: operand width, even, >= 4.
REQ-002 SHALL have parameter LATENCY, default NBITSIN/2: core run cycles between start and stop, >= 1.
REQ-003 SHALL have port clock  in  1  master clock, all state updates on positive edge.
REQ-004 SHALL have port reset  in  1  master reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  operand request from upstream.
REQ-006 SHALL have port in_ready  out  1  block can accept an operand.
REQ-007 SHALL have port in_x  in  NBITSIN  operand.
REQ-008 SHALL have port out_valid  out  1  out_root holds a valid result.
REQ-009 SHALL have port out_ready  in  1  downstream consumes the result.
REQ-010 SHALL have port out_root  out  NBITSIN/2  registered square-root result.
REQ-011 SHALL have port core_start  out  1  one-cycle start pulse to the sqrt core.
REQ-012 SHALL have port core_stop  out  1  one-cycle stop pulse to the sqrt core, loads its output register.
REQ-013 SHALL have port core_xin  out  NBITSIN  registered operand driven to the core.
REQ-014 SHALL have port core_sqrt  in  NBITSIN/2  result from the core.
REQ-015 SHALL have port op_count  out  16  number of results consumed, wraps modulo 2^16.

Function
REQ-016 SHALL implement FSM states IDLE, START, RUN, STOP, CAPT, HOLD; all outputs registered or decoded from state only.
REQ-017 SHALL assert in_ready only in IDLE.
REQ-018 IDLE: on in_valid=1 at an edge, SHALL latch in_x into core_xin and go to START; in_valid=0 stays IDLE.
REQ-019 START: SHALL drive core_start=1 for exactly one cycle, load run counter with LATENCY, go to RUN.
REQ-020 RUN: SHALL decrement counter each cycle, go to STOP after exactly LATENCY cycles in RUN.
REQ-021 STOP: SHALL drive core_stop=1 for exactly one cycle, go to CAPT.
REQ-022 CAPT: SHALL register core_sqrt into out_root and set out_valid=1 at the closing edge, go to HOLD.
REQ-023 Latency: out_valid SHALL rise LATENCY+3 edges after the accepting edge (19 for defaults).
REQ-024 HOLD: out_valid=1, out_root stable; on out_ready=1 SHALL clear out_valid, increment op_count, go to IDLE.
REQ-025 in_valid, in_x changes while not IDLE SHALL be ignored; core_xin SHALL stay constant from accept until return to IDLE.
REQ-026 core_start and core_stop SHALL never be high in the same cycle or for more than one consecutive cycle.
REQ-027 out_ready while out_valid=0 SHALL have no effect; op_count 0xFFFF+1 SHALL wrap to 0.
REQ-028 No new operand SHALL be accepted in the cycle out_valid falls (in_ready rises the next cycle).

Reset
REQ-029 reset=0 SHALL immediately, independent of clock, force IDLE, in_ready=1, out_valid=0, core_start=0, core_stop=0, core_xin=0, out_root=0, op_count=0, counter=0.
REQ-030 Reset asserted mid-operation SHALL abort it; after release first edge behaves as IDLE with no stale pulse or result.

Verification (bench connects the team's sequential sqrt core, NBITSIN=32)
REQ-031 in_x=123456 one-cycle in_valid, out_ready=1 -> core_start at edge+1, core_stop 16 cycles later, out_valid at edge 19, out_root=351, op_count=1.
REQ-032 in_x=0 then in_x=0xFFFFFFFF -> out_root=0 then 65535; op_count=2.
REQ-033 in_x=1000000, out_ready=0 for 5 cycles after out_valid -> out_valid and out_root=1000 held 5 cycles, in_ready=0, op_count increments once on out_ready.
REQ-034 in_valid held high with in_x changed to 49 during RUN -> ignored, result 351 for 123456, then 49 accepted next, result 7.
REQ-035 reset low asynchronously during RUN cycle 8 -> all outputs zero immediately, no core_stop, in_ready=1 after release; next op in_x=144 -> 12.
REQ-036 Random 10000 operands vs golden bitwise sqrt -> zero mismatches; core_start/core_stop never overlap.
